// File: rtl/afficheur_multiplexe.sv
// Time-multiplexed seven-segment driver: shadowed digit codes, prescaled digit scan,
// anti-ghosting blanking, leading-zero suppression and pin-level polarity selection.
module afficheur_multiplexe #(
   parameter int unsigned N_DIGITS      = 4,
   parameter int unsigned PRESCALE      = 50000,
   parameter int unsigned BLANK_CYC     = 2,
   parameter int unsigned ANODE_CATHODE = 0,
   parameter int unsigned AN_ACTIVE_LOW = 1,
   parameter int unsigned HEX_EN        = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*N_DIGITS-1:0] E,
   input  logic                  load,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic                  lz_en,
   output logic [0:6]            S,
   output logic                  DP,
   output logic [N_DIGITS-1:0]   AN,
   output logic                  frame
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [0:6]          S_OFF  = (ANODE_CATHODE != 0) ? 7'b0000000 : 7'b1111111;
   localparam logic                DP_OFF = (ANODE_CATHODE != 0) ? 1'b0 : 1'b1;
   localparam logic [N_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [PW-1:0]         presc_q;
   logic [IW-1:0]         idx_q;
   logic [4*N_DIGITS-1:0] shadow_e_q;
   logic [N_DIGITS-1:0]   shadow_dp_q;

   logic [3:0]            cur_code;
   logic [0:6]            seg;
   logic                  suppress;
   logic                  dp_cur;
   logic [N_DIGITS-1:0]   an_onehot;
   logic                  presc_wrap;
   logic [0:6]            s_pin;
   logic                  dp_pin;
   logic [N_DIGITS-1:0]   an_pin;

   always_comb begin
      cur_code = shadow_e_q[int'(idx_q)*4 +: 4];
      dp_cur   = shadow_dp_q[idx_q];
      presc_wrap = (presc_q == PW'(PRESCALE - 1));

      // Segment patterns are active-high with a in the leftmost position.
      seg = 7'b0000000;
      case (cur_code)
         4'd0:  seg = 7'b1111110;
         4'd1:  seg = 7'b0110000;
         4'd2:  seg = 7'b1101101;
         4'd3:  seg = 7'b1111001;
         4'd4:  seg = 7'b0110011;
         4'd5:  seg = 7'b1011011;
         4'd6:  seg = 7'b1011111;
         4'd7:  seg = 7'b1110000;
         4'd8:  seg = 7'b1111111;
         4'd9:  seg = 7'b1111011;
         4'd10: seg = (HEX_EN != 0) ? 7'b1110111 : 7'b0000000;
         4'd11: seg = (HEX_EN != 0) ? 7'b0011111 : 7'b0000000;
         4'd12: seg = (HEX_EN != 0) ? 7'b1001110 : 7'b0000000;
         4'd13: seg = (HEX_EN != 0) ? 7'b0111101 : 7'b0000000;
         4'd14: seg = (HEX_EN != 0) ? 7'b1001111 : 7'b0000000;
         4'd15: seg = (HEX_EN != 0) ? 7'b1000111 : 7'b0000000;
         default: seg = 7'b0000000;
      endcase

      // A digit is a leading zero when it and every digit to its left are zero.
      suppress = 1'b0;
      if (lz_en && (idx_q != '0)) begin
         suppress = 1'b1;
         for (int j = 0; j < int'(N_DIGITS); j++) begin
            if ((j >= int'(idx_q)) && (shadow_e_q[j*4 +: 4] != 4'd0)) suppress = 1'b0;
         end
      end
      if (suppress) seg = 7'b0000000;

      an_onehot = '0;
      if (presc_q >= PW'(BLANK_CYC)) an_onehot[idx_q] = 1'b1;

      s_pin  = (ANODE_CATHODE != 0) ? seg : ~seg;
      dp_pin = (ANODE_CATHODE != 0) ? dp_cur : ~dp_cur;
      an_pin = (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q     <= '0;
         idx_q       <= '0;
         shadow_e_q  <= '0;
         shadow_dp_q <= '0;
         S           <= S_OFF;
         DP          <= DP_OFF;
         AN          <= AN_OFF;
         frame       <= 1'b0;
      end else begin
         if (presc_wrap) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
         end else begin
            presc_q <= presc_q + 1'b1;
         end
         if (load) begin
            shadow_e_q  <= E;
            shadow_dp_q <= dp_in;
         end
         S     <= s_pin;
         DP    <= dp_pin;
         AN    <= an_pin;
         frame <= (presc_q == '0) && (idx_q == '0);
      end
   end

endmodule

// File: tb/tb_afficheur_multiplexe.sv
// Bench for afficheur_multiplexe: two polarity/hex configurations driven in parallel and
// checked cycle by cycle against an arithmetic model of the scan timeline.
module tb_afficheur_multiplexe;
   localparam int N = 4;
   localparam int P = 4;
   localparam int B = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic        lz_en = 1'b0;
   logic [15:0] e = 16'h0000;
   logic [3:0]  dp_in = 4'h0;

   logic [0:6] s0, s1;
   logic       dp0, dp1, fr0, fr1;
   logic [3:0] an0, an1;

   always #5 clk = ~clk;

   afficheur_multiplexe #(
      .N_DIGITS(N), .PRESCALE(P), .BLANK_CYC(B),
      .ANODE_CATHODE(0), .AN_ACTIVE_LOW(1), .HEX_EN(0)
   ) dut0 (
      .clk(clk), .rst(rst), .E(e), .load(load), .dp_in(dp_in), .lz_en(lz_en),
      .S(s0), .DP(dp0), .AN(an0), .frame(fr0)
   );

   afficheur_multiplexe #(
      .N_DIGITS(N), .PRESCALE(P), .BLANK_CYC(B),
      .ANODE_CATHODE(1), .AN_ACTIVE_LOW(0), .HEX_EN(1)
   ) dut1 (
      .clk(clk), .rst(rst), .E(e), .load(load), .dp_in(dp_in), .lz_en(lz_en),
      .S(s1), .DP(dp1), .AN(an1), .frame(fr1)
   );

   int checks = 0;
   int errors = 0;
   int frames = 0;

   // Model state: cycles elapsed since reset release plus the loaded display contents.
   int          k = 0;
   logic [15:0] sh_e = 16'h0000;
   logic [3:0]  sh_dp = 4'h0;
   logic [6:0]  tab [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input int hex, input int ac, input int anl,
                                 output logic [0:6] s, output logic dp,
                                 output logic [3:0] an, output logic fr);
      int         presc, idx;
      logic [3:0] code;
      logic [6:0] seg;
      logic       dpv;
      logic [3:0] oh;
      if (rst) begin
         seg = 7'h00; dpv = 1'b0; oh = 4'h0; fr = 1'b0;
      end else begin
         presc = k % P;
         idx   = (k / P) % N;
         code  = sh_e[idx*4 +: 4];
         seg   = (code < 10 || hex != 0) ? tab[code] : 7'h00;
         if (lz_en && idx > 0 && (sh_e >> (idx*4)) == 16'h0) seg = 7'h00;
         dpv   = sh_dp[idx];
         oh    = (presc < B) ? 4'h0 : 4'(1 << idx);
         fr    = ((k % (P*N)) == 0);
      end
      s  = (ac != 0) ? seg : ~seg;
      dp = (ac != 0) ? dpv : ~dpv;
      an = (anl != 0) ? ~oh : oh;
   endfunction

   task automatic step();
      logic [0:6] es0, es1;
      logic       edp0, edp1, efr0, efr1;
      logic [3:0] ean0, ean1;
      model(0, 0, 1, es0, edp0, ean0, efr0);
      model(1, 1, 0, es1, edp1, ean1, efr1);
      if (rst) begin
         k = 0; sh_e = 16'h0; sh_dp = 4'h0;
      end else begin
         if (load) begin sh_e = e; sh_dp = dp_in; end
         k++;
      end
      @(posedge clk);
      #1;
      chk("s0", 32'(s0), 32'(es0));
      chk("dp0", 32'(dp0), 32'(edp0));
      chk("an0", 32'(an0), 32'(ean0));
      chk("frame0", 32'(fr0), 32'(efr0));
      chk("s1", 32'(s1), 32'(es1));
      chk("dp1", 32'(dp1), 32'(edp1));
      chk("an1", 32'(an1), 32'(ean1));
      chk("frame1", 32'(fr1), 32'(efr1));
      if (fr0) frames++;
   endtask

   task automatic load_step(input logic [15:0] val, input logic [3:0] dpv);
      e = val; dp_in = dpv; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      tab[0]  = 7'b1111110; tab[1]  = 7'b0110000; tab[2]  = 7'b1101101; tab[3]  = 7'b1111001;
      tab[4]  = 7'b0110011; tab[5]  = 7'b1011011; tab[6]  = 7'b1011111; tab[7]  = 7'b1110000;
      tab[8]  = 7'b1111111; tab[9]  = 7'b1111011; tab[10] = 7'b1110111; tab[11] = 7'b0011111;
      tab[12] = 7'b1001110; tab[13] = 7'b0111101; tab[14] = 7'b1001111; tab[15] = 7'b1000111;

      #1;
      repeat (2) step();
      chk("reset_s0_literal", 32'(s0), 32'h7F);
      chk("reset_an0_literal", 32'(an0), 32'hF);
      rst = 1'b0;

      // Basic scan of 1234 with one decimal point; two frames expected in 32 cycles.
      load_step(16'h1234, 4'b0100);
      frames = 0;
      repeat (32) step();
      chk("frame_count", frames, 2);

      // Leading-zero suppression, including the all-zero case.
      lz_en = 1'b1;
      load_step(16'h0050, 4'b1000);
      repeat (16) step();
      load_step(16'h0000, 4'b0000);
      repeat (16) step();
      lz_en = 1'b0;

      // Hex codes and the polarity checks on 8 and 1.
      load_step(16'h00AF, 4'b0011);
      repeat (16) step();
      load_step(16'h8181, 4'b0000);
      repeat (16) step();

      // Load on the same edge that advances the scan to digit 1.
      load_step(16'h1234, 4'b0000);
      for (int i = 0; i < 16 && (k % 16) != 3; i++) step();
      load_step(16'h9999, 4'b0010);
      repeat (8) step();

      // Reset pulse in the middle of slot 2.
      for (int i = 0; i < 16 && (k % 16) != 9; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (20) step();

      // Randomized traffic with occasional loads, resets and lz toggles.
      repeat (300) begin
         rst   = ($urandom % 64) == 0;
         load  = ($urandom % 6) == 0;
         e     = 16'($urandom) >> $urandom_range(0, 16);
         dp_in = 4'($urandom);
         if (($urandom % 16) == 0) lz_en = ~lz_en;
         step();
      end
      rst = 1'b0;
      load = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/afficheur_multiplexe.md
AFFICHEUR_MULTIPLEXE -- requirements
Module: afficheur_multiplexe

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter PRESCALE, default 50000, clk cycles per digit slot (>= 2).
REQ-003 SHALL have parameter BLANK_CYC, default 2, anti-ghosting cycles at slot start with no digit enabled (< PRESCALE).
REQ-004 SHALL have parameter ANODE_CATHODE, default 0, where 0 makes S and DP active-low and 1 makes them active-high.
REQ-005 SHALL have parameter AN_ACTIVE_LOW, default 1, where 1 makes AN active-low.
REQ-006 SHALL have parameter HEX_EN, default 0, where 1 decodes codes 10..15 as A,b,C,d,E,F.
REQ-007 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port E, input, 4*N_DIGITS bits: digit codes, with E[3:0] as digit 0 (rightmost).
REQ-010 SHALL have port load, input, 1 bit: when high, E and dp_in are captured on the clock edge.
REQ-011 SHALL have port dp_in, input, N_DIGITS bits: per-digit decimal-point request.
REQ-012 SHALL have port lz_en, input, 1 bit: enables leading-zero suppression.
REQ-013 SHALL have port S, output, [0:6]: segments a..g, with S[0]=a.
REQ-014 SHALL have port DP, output, 1 bit: decimal-point segment.
REQ-015 SHALL have port AN, output, N_DIGITS bits: one-hot digit enable.
REQ-016 SHALL have port frame, output, 1 bit: one-cycle pulse at the start of each full scan.

Function
REQ-017 SHALL hold a shadow register of E and dp_in, updated only on clock edges where load=1; the display uses only the shadow.
REQ-018 SHALL run a prescaler counting 0..PRESCALE-1 that wraps to 0; the digit index SHALL advance on the wrap.
REQ-019 SHALL wrap the digit index from N_DIGITS-1 to 0, and frame SHALL pulse high for the one cycle in which the index becomes 0.
REQ-020 SHALL decode codes 0..9 with active-high patterns (a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-021 SHALL decode codes 10..15 with HEX_EN=1 as A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-022 SHALL decode codes 10..15 with HEX_EN=0 as all segments off, with no latching of the previous value.
REQ-023 SHALL blank digit i, with lz_en=1, when its code and the codes of all higher digits are 0; digit 0 is never suppressed.
REQ-024 SHALL show DP for the current digit from the shadow dp bit, including on suppressed digits.
REQ-025 SHALL hold AN all-inactive while the prescaler is less than BLANK_CYC; otherwise only the current digit's bit is active.
REQ-026 SHALL register S, DP, AN and frame, with exactly 1 clk of latency from prescaler/index/shadow state to outputs.
REQ-027 SHALL, when load coincides with a digit advance, show the newly loaded code for the new digit.
REQ-028 SHALL apply the polarity parameters only at the output stage; inactive means all segments and digits off at the pin level.

Reset
REQ-029 SHALL, while rst=1, clear the prescaler, digit index and shadow register to 0, drive S, DP and AN inactive and frame to 0.
REQ-030 SHALL, after rst is released, start the first slot on digit 0 with prescaler 0; rst asserted mid-slot SHALL abort the slot on the next edge.

Verification
REQ-031 SHALL be verified with N=4, PRESCALE=4, BLANK_CYC=1, load E=16'h1234 -> AN cycles digits 0,1,2,3, showing S codes for 4,3,2,1, 4 clk each, with AN off 1 clk per slot, and frame every 16 clk.
REQ-032 SHALL be verified with lz_en=1 and E=16'h0050 -> digits 3,2 blank, digit 1=5, digit 0=0; with E=16'h0000, only digit 0 shows 0.
REQ-033 SHALL be verified with HEX_EN=0 and E=16'h00AF -> digits 0,1 all segments off; with HEX_EN=1 -> F and A patterns.
REQ-034 SHALL be verified with ANODE_CATHODE=0 and digit code 8 -> S=0000000; with ANODE_CATHODE=1 and code 1 -> S=0110000.
REQ-035 SHALL be verified by asserting rst for 1 clk during slot 2 -> the next edge gives all outputs inactive and index 0, and the shadow reads 0 thereafter.
REQ-036 SHALL be verified by load=1 on the same edge as the slot 1 advance with new E=16'h9999 -> digit 1 shows 9 in the first enabled cycle.
